uart_alu_sequencer: RTL and testbench
=====================================

UART_ALU_SEQUENCER -- requirements
Module: uart_alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: operand, opcode and result width in bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 262144: idle cycles allowed between bytes of one frame.
REQ-003 SHALL have port i_clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_rx_empty  input  1  RX FIFO empty flag.
REQ-006 SHALL have port i_rx_data  input  DATA_WIDTH  RX FIFO head word, valid while i_rx_empty=0 (first-word-fall-through).
REQ-007 SHALL have port o_rd_uart  output  1  one-cycle pop strobe to RX FIFO.
REQ-008 SHALL have port i_tx_full  input  1  TX FIFO full flag.
REQ-009 SHALL have port o_tx_data  output  DATA_WIDTH  result word to TX FIFO.
REQ-010 SHALL have port o_wr_uart  output  1  one-cycle push strobe to TX FIFO.
REQ-011 SHALL have port o_busy  output  1  high whenever state is not GET_A.
REQ-012 SHALL have port o_err  output  1  one-cycle pulse on invalid opcode or frame timeout.

Function
REQ-013 SHALL run FSM GET_A -> GET_B -> GET_OP -> EXEC -> SEND -> GET_A; a frame is three bytes in order A, B, opcode.
REQ-014 SHALL, in GET_A/GET_B/GET_OP, assert o_rd_uart for exactly one cycle when i_rx_empty=0, register i_rx_data that cycle and advance; SHALL hold state while i_rx_empty=1.
REQ-015 SHALL never assert o_rd_uart while i_rx_empty=1 or outside GET_A/GET_B/GET_OP.
REQ-016 SHALL, in EXEC (one cycle), register the result into o_tx_data and go to SEND.
REQ-017 SHALL, in SEND, assert o_wr_uart for one cycle when i_tx_full=0 and return to GET_A; while i_tx_full=1 SHALL hold SEND with o_tx_data stable.
REQ-018 SHALL give latency of exactly 2 cycles from opcode pop cycle to o_wr_uart when i_tx_full=0.
REQ-019 SHALL decode opcodes: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SRL 0x02, SRA 0x03.
REQ-020 SHALL compute ADD/SUB modulo 2^DATA_WIDTH, carry/borrow discarded; SUB is A-B.
REQ-021 SHALL shift A by unsigned B; B>=DATA_WIDTH gives 0 for SRL and all-sign-bit for SRA.
REQ-022 SHALL, on any other opcode, transmit 0x00 and pulse o_err in the EXEC cycle.
REQ-023 SHALL start a new frame immediately after SEND; back-to-back frames need no idle cycle.

Reset
REQ-024 SHALL, on i_reset low, asynchronously enter GET_A and clear operands, opcode and o_tx_data to 0; o_rd_uart, o_wr_uart, o_busy, o_err low.
REQ-025 SHALL discard any partial frame on reset mid-operation; no o_wr_uart after reset release until a full new frame is read.

Configuration
REQ-026 SHALL, with macro UART_ALU_SEQ_TIMEOUT_EN defined, count consecutive cycles with i_rx_empty=1 in GET_B/GET_OP; at TIMEOUT_CYCLES discard the frame, pulse o_err, return to GET_A; counter clears on each pop.
REQ-027 SHALL, without UART_ALU_SEQ_TIMEOUT_EN, contain no timeout counter, wait indefinitely, and raise o_err only per REQ-022.

Structure
REQ-028 SHALL take opcode constants and the FSM state enumeration from shared package uart_alu_pkg.
REQ-029 SHALL instantiate combinational sub-module alu_core (inputs A, B, opcode; outputs result, invalid flag); sequencer holds all state.

Verification
REQ-030 SHALL test ADD: push 0x40, 0x40, 0x20 -> one o_wr_uart with o_tx_data=0x80, 2 cycles after third pop.
REQ-031 SHALL test SUB wrap and SRA: frames (0x01,0x02,0x22) -> 0xFF; (0x80,0x09,0x03) -> 0xFF.
REQ-032 SHALL test invalid opcode: (0x12,0x34,0x04) -> o_tx_data=0x00, o_err pulse 1 cycle, frame sent.
REQ-033 SHALL test backpressure: i_tx_full=1 for 50 cycles during SEND -> o_wr_uart only after release, o_tx_data stable, no RX pops.
REQ-034 SHALL test reset mid-frame: A, B popped, i_reset low 3 cycles, then frame (0x0F,0xF0,0x25) -> single output 0xFF.
REQ-035 SHALL test timeout (macro on, TIMEOUT_CYCLES=100): A popped, RX empty 100 cycles -> o_err pulse, GET_A; next 3 bytes form a fresh frame.

Source files
------------

// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU sequencer: FSM state encoding and
// the opcode values understood by alu_core.
package uart_alu_pkg;

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_OP,
        EXEC,
        SEND
    } seq_state_t;

    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_SUB = 8'h22;
    localparam logic [7:0] OP_AND = 8'h24;
    localparam logic [7:0] OP_OR  = 8'h25;
    localparam logic [7:0] OP_XOR = 8'h26;
    localparam logic [7:0] OP_NOR = 8'h27;
    localparam logic [7:0] OP_SRL = 8'h02;
    localparam logic [7:0] OP_SRA = 8'h03;

endpackage

// File: rtl/uart_alu_sequencer_alu_core.sv
// Combinational ALU for the UART ALU sequencer. Unknown opcodes give a
// zero result and raise invalid.
module alu_core
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] opcode,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  invalid
);

    // Shifting by the full width or more saturates rather than wrapping.
    logic shift_big;
    assign shift_big = 32'(b) >= DATA_WIDTH;

    // Opcode decode and result selection.
    always_comb begin
        result  = '0;
        invalid = 1'b0;
        case (opcode)
            DATA_WIDTH'(OP_ADD): result = a + b;
            DATA_WIDTH'(OP_SUB): result = a - b;
            DATA_WIDTH'(OP_AND): result = a & b;
            DATA_WIDTH'(OP_OR):  result = a | b;
            DATA_WIDTH'(OP_XOR): result = a ^ b;
            DATA_WIDTH'(OP_NOR): result = ~(a | b);
            DATA_WIDTH'(OP_SRL): result = shift_big ? '0 : (a >> b);
            DATA_WIDTH'(OP_SRA): result = shift_big ? {DATA_WIDTH{a[DATA_WIDTH-1]}}
                                                    : $unsigned($signed(a) >>> b);
            default:             invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_alu_sequencer.sv
// UART ALU sequencer: reads frames (A, B, opcode) from an RX FIFO, computes
// the result with alu_core and pushes it to a TX FIFO.
// Optional feature: define UART_ALU_SEQ_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYCLES consecutive empty cycles while waiting for B or the opcode.
module uart_alu_sequencer
    import uart_alu_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 262144
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_empty,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic                  o_rd_uart,
    input  logic                  i_tx_full,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_wr_uart,
    output logic                  o_busy,
    output logic                  o_err
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_alu_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_t            state;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] opcode;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_invalid;
    logic                  in_get;
    logic                  timeout_hit;

    alu_core #(.DATA_WIDTH(DATA_WIDTH)) u_alu_core (
        .a       (op_a),
        .b       (op_b),
        .opcode  (opcode),
        .result  (alu_result),
        .invalid (alu_invalid)
    );

    // The FIFO strobes are decoded from the state register so a pop or push
    // lands in the same cycle as the flag it depends on; gating with the
    // reset keeps them quiet while reset is held.
    assign in_get    = (state == GET_A) || (state == GET_B) || (state == GET_OP);
    assign o_rd_uart = i_reset && in_get && !i_rx_empty;
    assign o_wr_uart = i_reset && (state == SEND) && !i_tx_full;
    assign o_busy    = (state != GET_A);
    assign o_err     = ((state == EXEC) && alu_invalid) || timeout_hit;

`ifdef UART_ALU_SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt;
    logic             mid_frame;

    assign mid_frame   = (state == GET_B) || (state == GET_OP);
    assign timeout_hit = mid_frame && i_rx_empty && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count consecutive empty cycles while a frame is partially received.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idle_cnt <= '0;
        end else if (!mid_frame || o_rd_uart || timeout_hit) begin
            idle_cnt <= '0;
        end else if (i_rx_empty) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Frame sequencing: collect operands, execute, then hand off the result.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= GET_A;
            op_a      <= '0;
            op_b      <= '0;
            opcode    <= '0;
            o_tx_data <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (!i_rx_empty) begin
                        op_a  <= i_rx_data;
                        state <= GET_B;
                    end
                end
                GET_B: begin
                    if (timeout_hit) begin
                        state <= GET_A;
                    end else if (!i_rx_empty) begin
                        op_b  <= i_rx_data;
                        state <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (timeout_hit) begin
                        state <= GET_A;
                    end else if (!i_rx_empty) begin
                        opcode <= i_rx_data;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    o_tx_data <= alu_result;
                    state     <= SEND;
                end
                SEND: begin
                    if (!i_tx_full) begin
                        state <= GET_A;
                    end
                end
                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// Directed self-checking bench for uart_alu_sequencer. The RX FIFO is a
// first-word-fall-through queue; results and strobes are sampled on the
// falling clock edge.
module tb_uart_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rd;
    logic       tx_full = 1'b0;
    logic [7:0] tx_data;
    logic       wr;
    logic       busy;
    logic       err;

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .DATA_WIDTH     (8),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst_n),
        .i_rx_empty (rx_empty),
        .i_rx_data  (rx_data),
        .o_rd_uart  (rd),
        .i_tx_full  (tx_full),
        .o_tx_data  (tx_data),
        .o_wr_uart  (wr),
        .o_busy     (busy),
        .o_err      (err)
    );

    logic [7:0] rx_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int pops = 0;
    int writes = 0;
    int errs = 0;
    int last_pop = -1;
    int last_wr = -1;
    int last_err = -1;
    int rd_empty_viol = 0;
    logic [7:0] last_wr_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        rx_empty = (rx_q.size() == 0);
        rx_data  = rx_empty ? 8'h00 : rx_q[0];
    endtask

    task automatic push(input logic [7:0] v);
        rx_q.push_back(v);
        drive_rx();
    endtask

    // One clock: sample strobes at the falling edge, then retire a pop
    // just after the rising edge.
    task automatic step();
        logic rd_now;
        @(negedge clk);
        cyc++;
        rd_now = rd;
        if (rd && rx_empty) rd_empty_viol++;
        if (rd) begin pops++; last_pop = cyc; end
        if (wr) begin writes++; last_wr = cyc; last_wr_data = tx_data; end
        if (err) begin errs++; last_err = cyc; end
        @(posedge clk);
        #1;
        if (rd_now && rx_q.size() > 0) void'(rx_q.pop_front());
        drive_rx();
    endtask

    task automatic wait_writes(input string tag, input int target, input int budget);
        int k = 0;
        while (writes < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_wr_seen"}, 32'(writes), 32'(target));
    endtask

    task automatic wait_pops(input string tag, input int target, input int budget);
        int k = 0;
        while (pops < target && k < budget) begin
            step();
            k++;
        end
        check({tag, "_pops"}, 32'(pops), 32'(target));
    endtask

    // Push a frame (optionally without A, when A was already consumed) and
    // check result, latency and error behaviour.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] op, input logic [7:0] exp,
                             input bit exp_err, input bit skip_a);
        int w0 = writes;
        int e0 = errs;
        if (!skip_a) push(a);
        push(b);
        push(op);
        wait_writes(tag, w0 + 1, 30);
        check({tag, "_data"}, 32'(last_wr_data), 32'(exp));
        check({tag, "_latency"}, 32'(last_wr - last_pop), 32'd2);
        check({tag, "_errcnt"}, 32'(errs - e0), 32'(exp_err));
        if (exp_err) check({tag, "_errcycle"}, 32'(last_err), 32'(last_pop + 1));
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, p0, e0, wfirst, bad_stable;

        // Reset with a full frame already waiting: nothing may be popped.
        push(8'h40);
        push(8'h40);
        push(8'h20);
        step(); step(); step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(rd), 32'd0);
        check("rst_wr", 32'(wr), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_txdata", 32'(tx_data), 32'd0);
        check("rst_nopops", 32'(pops), 32'd0);

        // ADD 0x40 + 0x40 using the bytes queued during reset.
        rst_n = 1'b1;
        wait_writes("add", 1, 20);
        check("add_data", 32'(last_wr_data), 32'h80);
        check("add_latency", 32'(last_wr - last_pop), 32'd2);
        check("add_noerr", 32'(errs), 32'd0);

        run_frame("sub_wrap", 8'h01, 8'h02, 8'h22, 8'hFF, 1'b0, 1'b0);
        run_frame("sra_big",  8'h80, 8'h09, 8'h03, 8'hFF, 1'b0, 1'b0);
        run_frame("srl_big",  8'h80, 8'h09, 8'h02, 8'h00, 1'b0, 1'b0);
        run_frame("srl_4",    8'hF0, 8'h04, 8'h02, 8'h0F, 1'b0, 1'b0);
        run_frame("sra_1",    8'h80, 8'h01, 8'h03, 8'hC0, 1'b0, 1'b0);
        run_frame("sra_7",    8'h40, 8'h07, 8'h03, 8'h00, 1'b0, 1'b0);
        run_frame("add_wrap", 8'hFF, 8'h02, 8'h20, 8'h01, 1'b0, 1'b0);
        run_frame("and",      8'hF0, 8'h3C, 8'h24, 8'h30, 1'b0, 1'b0);
        run_frame("or",       8'hF0, 8'h3C, 8'h25, 8'hFC, 1'b0, 1'b0);
        run_frame("xor",      8'hF0, 8'h3C, 8'h26, 8'hCC, 1'b0, 1'b0);
        run_frame("nor",      8'hF0, 8'h3C, 8'h27, 8'h03, 1'b0, 1'b0);
        run_frame("invalid",  8'h12, 8'h34, 8'h04, 8'h00, 1'b1, 1'b0);

        // Backpressure, with the next frame already queued behind it.
        tx_full = 1'b1;
        w0 = writes;
        p0 = pops;
        push(8'hF0); push(8'h0F); push(8'h20);
        push(8'h0A); push(8'h05); push(8'h22);
        wait_pops("bp", p0 + 3, 10);
        step();
        bad_stable = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (tx_data !== 8'hFF) bad_stable++;
        end
        check("bp_nowrite", 32'(writes), 32'(w0));
        check("bp_nopop", 32'(pops), 32'(p0 + 3));
        check("bp_stable", 32'(bad_stable), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        tx_full = 1'b0;
        step();
        check("bp_release_wr", 32'(writes), 32'(w0 + 1));
        check("bp_release_data", 32'(last_wr_data), 32'hFF);
        wfirst = last_wr;
        wait_writes("b2b", w0 + 2, 20);
        check("b2b_data", 32'(last_wr_data), 32'h05);
        check("b2b_gap", 32'(last_wr - wfirst), 32'd5);

        // Reset in the middle of a frame discards A and B.
        w0 = writes;
        p0 = pops;
        push(8'h11); push(8'h22);
        wait_pops("midrst", p0 + 2, 10);
        rst_n = 1'b0;
        step(); step(); step();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_txdata", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("midrst_nowrite", 32'(writes), 32'(w0));
        run_frame("midrst_or", 8'h0F, 8'hF0, 8'h25, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        check("midrst_single", 32'(writes), 32'(w0 + 1));

        // Long gap after A: either the frame times out or it waits forever.
        p0 = pops;
        e0 = errs;
        push(8'h05);
        wait_pops("gap", p0 + 1, 10);
`ifdef UART_ALU_SEQ_TIMEOUT_EN
        begin
            int k = 0;
            while (errs == e0 && k < 150) begin
                step();
                k++;
            end
        end
        check("to_err", 32'(errs), 32'(e0 + 1));
        check("to_cycle", 32'(last_err - last_pop), 32'd100);
        check("to_idle", 32'(busy), 32'd0);
        run_frame("to_fresh", 8'h03, 8'h07, 8'h20, 8'h0A, 1'b0, 1'b0);
`else
        for (int i = 0; i < 150; i++) step();
        check("wait_noerr", 32'(errs), 32'(e0));
        check("wait_busy", 32'(busy), 32'd1);
        run_frame("wait_resume", 8'h05, 8'h03, 8'h22, 8'h02, 1'b0, 1'b1);
`endif

        check("rd_never_empty", 32'(rd_empty_viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
